// File: rtl/stepdown_corestate_seq_if.sv
// Control/status bundle between the brick controller and the stepdown core-state sequencer.
interface stepdown_corestate_seq_if;
  logic       en;
  logic       pgood;
  logic       ocp;
  logic       ovp;
  logic [2:0] cstate;
  logic [5:0] ss_code;
  logic       drv_en;
  logic       pg_ok;
  logic       fault;
  logic [2:0] retry_cnt;

  modport master (
    output en, pgood, ocp, ovp,
    input  cstate, ss_code, drv_en, pg_ok, fault, retry_cnt
  );

  modport slave (
    input  en, pgood, ocp, ovp,
    output cstate, ss_code, drv_en, pg_ok, fault, retry_cnt
  );
endinterface

// File: rtl/stepdown_corestate_seq.sv
// VMAX-6 stepdown core-state sequencer: precharge, soft-start ramp, regulation,
// OCP/OVP fault handling with cooldown and bounded auto-retry. All outputs registered.
module stepdown_corestate_seq #(
  parameter int PRECHG_CYC  = 16,
  parameter int SS_STEP_CYC = 4,
  parameter int SS_MAX      = 63,
  parameter int PG_TO       = 255,
  parameter int PG_DEB      = 8,
  parameter int COOL_CYC    = 1024,
  parameter int RETRY_MAX   = 3
) (
  input  logic                          CELCLK,
  input  logic                          CELRST,
  input  logic                          CELV,
  input  logic                          CELG,
  input  logic                          SUB,
  stepdown_corestate_seq_if.slave       sif
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PRE   = 3'd1,
    S_SS    = 3'd2,
    S_REG   = 3'd3,
    S_FAULT = 3'd4,
    S_COOL  = 3'd5,
    S_LATCH = 3'd6,
    S_BAD   = 3'd7
  } state_t;

  localparam logic [7:0]  PRE_LAST  = 8'(PRECHG_CYC - 1);
  localparam logic [3:0]  STEP_LAST = 4'(SS_STEP_CYC - 1);
  localparam logic [5:0]  SS_TOP    = 6'(SS_MAX);
  localparam logic [7:0]  PG_LAST   = 8'(PG_TO - 1);
  localparam logic [3:0]  DEB_LAST  = 4'(PG_DEB - 1);
  localparam logic [11:0] COOL_LAST = 12'(COOL_CYC - 1);
  localparam logic [2:0]  RETRY_TOP = 3'(RETRY_MAX);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_pre_cnt;
  logic [7:0]  r_pg_cnt;
  logic [3:0]  r_step_cnt;
  logic [3:0]  r_deb_cnt;
  logic [11:0] r_cool_cnt;
  logic [5:0]  r_ss_code;
  logic [2:0]  r_retry_cnt;
  logic        r_drv_en;
  logic        r_pg_ok;
  logic        r_fault;
  logic        w_flt;
  logic        w_ss_top;
  logic        w_unused_supply;

  // Supply and substrate pins are carried for netlist completeness only.
  assign w_unused_supply = ^{CELV, CELG, SUB};

  assign w_flt    = sif.ocp | sif.ovp;
  assign w_ss_top = (r_ss_code == SS_TOP);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_OFF: begin
        if (sif.en) w_state_next = S_PRE;
      end
      S_PRE: begin
        if (w_flt)                       w_state_next = S_FAULT;
        else if (!sif.en)                w_state_next = S_OFF;
        else if (r_pre_cnt == PRE_LAST)  w_state_next = S_SS;
      end
      S_SS: begin
        if (w_flt)                       w_state_next = S_FAULT;
        else if (!sif.en)                w_state_next = S_OFF;
        else if (w_ss_top) begin
          // pgood only counts once the ramp has finished
          if (sif.pgood)                 w_state_next = S_REG;
          else if (r_pg_cnt == PG_LAST)  w_state_next = S_FAULT;
        end
      end
      S_REG: begin
        if (w_flt)                       w_state_next = S_FAULT;
        else if (!sif.en)                w_state_next = S_OFF;
        else if (!sif.pgood && (r_deb_cnt == DEB_LAST))
                                         w_state_next = S_FAULT;
      end
      S_FAULT: begin
        w_state_next = S_COOL;
      end
      S_COOL: begin
        if (!sif.en)                     w_state_next = S_OFF;
        else if (r_cool_cnt == COOL_LAST)
          w_state_next = (r_retry_cnt < RETRY_TOP) ? S_PRE : S_LATCH;
      end
      S_LATCH: begin
        if (!sif.en)                     w_state_next = S_OFF;
      end
      default: begin
        w_state_next = S_OFF;
      end
    endcase
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      r_state     <= S_OFF;
      r_pre_cnt   <= '0;
      r_pg_cnt    <= '0;
      r_step_cnt  <= '0;
      r_deb_cnt   <= '0;
      r_cool_cnt  <= '0;
      r_ss_code   <= '0;
      r_retry_cnt <= '0;
      r_drv_en    <= 1'b0;
      r_pg_ok     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_drv_en <= (w_state_next == S_SS) || (w_state_next == S_REG);
      r_pg_ok  <= (w_state_next == S_REG);
      r_fault  <= (w_state_next == S_FAULT) || (w_state_next == S_COOL) ||
                  (w_state_next == S_LATCH);

      if ((w_state_next == S_OFF) || ((w_state_next == S_REG) && (r_state != S_REG)))
        r_retry_cnt <= '0;
      else if ((r_state == S_COOL) && (w_state_next == S_PRE))
        r_retry_cnt <= r_retry_cnt + 3'd1;

      if (w_state_next != r_state) begin
        // Every counter starts from zero in the state being entered.
        r_pre_cnt  <= '0;
        r_pg_cnt   <= '0;
        r_step_cnt <= '0;
        r_deb_cnt  <= '0;
        r_cool_cnt <= '0;
        r_ss_code  <= (w_state_next == S_REG) ? SS_TOP : 6'd0;
      end else begin
        case (r_state)
          S_PRE: r_pre_cnt <= r_pre_cnt + 8'd1;
          S_SS: begin
            if (w_ss_top) begin
              r_pg_cnt <= r_pg_cnt + 8'd1;
            end else if (r_step_cnt == STEP_LAST) begin
              r_step_cnt <= '0;
              r_ss_code  <= r_ss_code + 6'd1;
            end else begin
              r_step_cnt <= r_step_cnt + 4'd1;
            end
          end
          S_REG:   r_deb_cnt  <= sif.pgood ? 4'd0 : (r_deb_cnt + 4'd1);
          S_COOL:  r_cool_cnt <= r_cool_cnt + 12'd1;
          default: ;
        endcase
      end
    end
  end

  assign sif.cstate    = r_state;
  assign sif.ss_code   = r_ss_code;
  assign sif.drv_en    = r_drv_en;
  assign sif.pg_ok     = r_pg_ok;
  assign sif.fault     = r_fault;
  assign sif.retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_stepdown_corestate_seq.sv
// Bench for stepdown_corestate_seq: vector table, corner sequences and randomized run
// against a time-since-entry reference model.
module tb_stepdown_corestate_seq;
  localparam int PRECHG_CYC  = 16;
  localparam int SS_STEP_CYC = 4;
  localparam int SS_MAX      = 63;
  localparam int PG_TO       = 255;
  localparam int PG_DEB      = 8;
  localparam int COOL_CYC    = 1024;
  localparam int RETRY_MAX   = 3;

  typedef struct packed {
    logic [2:0] cs;
    logic [5:0] ss;
    logic       drv;
    logic       pgok;
    logic       flt;
    logic [2:0] rty;
  } outs_t;

  typedef struct {
    logic  en;
    logic  pg;
    logic  ocp;
    logic  ovp;
    int    n;
    outs_t exp;
  } vec_t;

  logic CELCLK = 1'b0;
  logic CELRST = 1'b1;
  logic CELV   = 1'b1;
  logic CELG   = 1'b0;
  logic SUB    = 1'b0;

  stepdown_corestate_seq_if bus();

  stepdown_corestate_seq #(
    .PRECHG_CYC(PRECHG_CYC), .SS_STEP_CYC(SS_STEP_CYC), .SS_MAX(SS_MAX),
    .PG_TO(PG_TO), .PG_DEB(PG_DEB), .COOL_CYC(COOL_CYC), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .CELCLK(CELCLK),
    .CELRST(CELRST),
    .CELV(CELV),
    .CELG(CELG),
    .SUB(SUB),
    .sif(bus.slave)
  );

  always #5 CELCLK = ~CELCLK;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  vec_t vecs[$];
  logic rnd_en;
  logic rnd_pg;

  // Reference model: state number, cycles since entry, pgood-low run, retries.
  int m_state = 0;
  int m_t     = 0;
  int m_low   = 0;
  int m_retry = 0;

  function automatic string fmt(outs_t o);
    return $sformatf("cs=%0d ss=%0d drv=%0d pgok=%0d flt=%0d rty=%0d",
                     o.cs, o.ss, o.drv, o.pgok, o.flt, o.rty);
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.cs   = bus.cstate;
    o.ss   = bus.ss_code;
    o.drv  = bus.drv_en;
    o.pgok = bus.pg_ok;
    o.flt  = bus.fault;
    o.rty  = bus.retry_cnt;
    return o;
  endfunction

  function automatic outs_t mk(int cs, int ss, int drv, int pgok, int flt, int rty);
    outs_t o;
    o.cs   = 3'(cs);
    o.ss   = 6'(ss);
    o.drv  = drv[0];
    o.pgok = pgok[0];
    o.flt  = flt[0];
    o.rty  = 3'(rty);
    return o;
  endfunction

  function automatic outs_t model_outs();
    int s;
    s = m_t / SS_STEP_CYC;
    if (s > SS_MAX) s = SS_MAX;
    return mk(m_state,
              (m_state == 2) ? s : ((m_state == 3) ? SS_MAX : 0),
              (m_state == 2 || m_state == 3) ? 1 : 0,
              (m_state == 3) ? 1 : 0,
              (m_state >= 4 && m_state <= 6) ? 1 : 0,
              m_retry);
  endfunction

  task automatic model_step(input logic rst, input logic en, input logic pg, input logic flt);
    int ns;
    int ramp_end;
    ramp_end = SS_MAX * SS_STEP_CYC;
    if (rst) begin
      m_state = 0; m_t = 0; m_low = 0; m_retry = 0;
      return;
    end
    ns = m_state;
    case (m_state)
      0: if (en) ns = 1;
      1: if (flt) ns = 4; else if (!en) ns = 0; else if (m_t + 1 == PRECHG_CYC) ns = 2;
      2: begin
        if (flt) ns = 4;
        else if (!en) ns = 0;
        else if (m_t >= ramp_end) begin
          if (pg) ns = 3;
          else if (m_t - ramp_end + 1 == PG_TO) ns = 4;
        end
      end
      3: begin
        if (flt) ns = 4;
        else if (!en) ns = 0;
        else begin
          m_low = pg ? 0 : m_low + 1;
          if (m_low == PG_DEB) ns = 4;
        end
      end
      4: ns = 5;
      5: begin
        if (!en) ns = 0;
        else if (m_t + 1 == COOL_CYC) begin
          if (m_retry < RETRY_MAX) begin m_retry++; ns = 1; end
          else ns = 6;
        end
      end
      6: if (!en) ns = 0;
      default: ns = 0;
    endcase
    if (ns != m_state) begin m_t = 0; m_low = 0; end
    else m_t++;
    if (ns == 0 || (ns == 3 && m_state != 3)) m_retry = 0;
    m_state = ns;
  endtask

  task automatic check(input string name, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {%s} required {%s}", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic setin(input logic en, input logic pg, input logic ocp, input logic ovp);
    bus.en    = en;
    bus.pgood = pg;
    bus.ocp   = ocp;
    bus.ovp   = ovp;
  endtask

  task automatic cyc();
    @(posedge CELCLK);
    model_step(CELRST, bus.en, bus.pgood, bus.ocp | bus.ovp);
    #1;
    cycle++;
    check($sformatf("model@%0d", cycle), dut_outs(), model_outs());
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic add(input logic en, input logic pg, input logic ocp, input logic ovp, input int n,
                     input int cs, input int ss, input int drv, input int pgok, input int flt,
                     input int rty);
    vec_t v;
    v.en = en; v.pg = pg; v.ocp = ocp; v.ovp = ovp; v.n = n;
    v.exp = mk(cs, ss, drv, pgok, flt, rty);
    vecs.push_back(v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    setin(0, 0, 0, 0);
    //    en pg oc ov  n     cs ss drv pgok flt rty
    add(0, 0, 0, 0, 1,     0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 1,     1, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 15,    1, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 1,     2, 0,  1, 0, 0, 0);
    add(1, 1, 0, 0, 4,     2, 1,  1, 0, 0, 0);
    add(1, 1, 0, 0, 247,   2, 62, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1,     2, 63, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1,     3, 63, 1, 1, 0, 0);
    add(1, 0, 0, 0, 7,     3, 63, 1, 1, 0, 0);
    add(1, 1, 0, 0, 1,     3, 63, 1, 1, 0, 0);
    add(1, 0, 0, 0, 8,     4, 0,  0, 0, 1, 0);
    add(1, 0, 0, 0, 1,     5, 0,  0, 0, 1, 0);
    add(1, 0, 1, 1, 1023,  5, 0,  0, 0, 1, 0);
    add(1, 0, 0, 0, 1,     1, 0,  0, 0, 0, 1);
    add(1, 0, 0, 0, 16,    2, 0,  1, 0, 0, 1);
    add(1, 0, 0, 0, 252,   2, 63, 1, 0, 0, 1);
    add(1, 1, 0, 0, 1,     3, 63, 1, 1, 0, 0);
    add(1, 1, 1, 0, 1,     4, 0,  0, 0, 1, 0);
    add(1, 1, 0, 0, 1,     5, 0,  0, 0, 1, 0);
    add(1, 1, 0, 0, 1024,  1, 0,  0, 0, 0, 1);
    add(0, 1, 0, 0, 1,     0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 269,   2, 63, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1,     3, 63, 1, 1, 0, 0);
    add(0, 1, 0, 1, 1,     4, 0,  0, 0, 1, 0);
    add(0, 1, 0, 0, 1,     5, 0,  0, 0, 1, 0);
    add(0, 1, 0, 0, 1,     0, 0,  0, 0, 0, 0);

    run(2);
    check("reset", dut_outs(), mk(0, 0, 0, 0, 0, 0));
    CELRST = 1'b0;

    foreach (vecs[i]) begin
      setin(vecs[i].en, vecs[i].pg, vecs[i].ocp, vecs[i].ovp);
      run(vecs[i].n);
      check($sformatf("row%0d", i), dut_outs(), vecs[i].exp);
      $display("row %0d: en=%0d pg=%0d ocp=%0d ovp=%0d x%0d -> %s", i, vecs[i].en, vecs[i].pg,
               vecs[i].ocp, vecs[i].ovp, vecs[i].n, fmt(dut_outs()));
    end

    // pgood timeout: FAULT exactly PG_TO cycles after ss_code first reads SS_MAX
    setin(1, 0, 0, 0);
    run(269);
    check("pgto_first63", dut_outs(), mk(2, 63, 1, 0, 0, 0));
    run(254);
    check("pgto_before", dut_outs(), mk(2, 63, 1, 0, 0, 0));
    run(1);
    check("pgto_fault", dut_outs(), mk(4, 0, 0, 0, 1, 0));
    setin(0, 0, 0, 0);
    run(2);
    check("pgto_off", dut_outs(), mk(0, 0, 0, 0, 0, 0));
    $display("seq pgood-timeout: %s", fmt(dut_outs()));

    // reset abort mid-ramp
    setin(1, 0, 0, 0);
    run(137);
    check("abort_ss30", dut_outs(), mk(2, 30, 1, 0, 0, 0));
    CELRST = 1'b1;
    run(1);
    check("abort_reset", dut_outs(), mk(0, 0, 0, 0, 0, 0));
    CELRST = 1'b0;
    setin(0, 0, 0, 0);
    run(1);
    $display("seq reset-abort: %s", fmt(dut_outs()));

    // persistent overcurrent: three retries then latch-off
    setin(1, 0, 1, 0);
    run(4104);
    check("persist_lastcool", dut_outs(), mk(5, 0, 0, 0, 1, 3));
    run(1);
    check("persist_latch", dut_outs(), mk(6, 0, 0, 0, 1, 3));
    run(10);
    check("persist_hold", dut_outs(), mk(6, 0, 0, 0, 1, 3));
    setin(0, 0, 1, 0);
    run(1);
    check("persist_off", dut_outs(), mk(0, 0, 0, 0, 0, 0));
    $display("seq persistent-fault: %s", fmt(dut_outs()));

    // randomized run against the model
    setin(0, 0, 0, 0);
    CELRST = 1'b1;
    run(1);
    CELRST = 1'b0;
    rnd_en = 1'b1;
    rnd_pg = 1'b0;
    for (int k = 0; k < 25000 && errors < 20; k++) begin
      if ($urandom_range(0, 399) == 0) rnd_en = ~rnd_en;
      if (rnd_pg) begin
        if ($urandom_range(0, 59) == 0) rnd_pg = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        rnd_pg = 1'b1;
      end
      setin(rnd_en, rnd_pg, ($urandom_range(0, 999) == 0), ($urandom_range(0, 999) == 0));
      cyc();
    end
    $display("seq random: ended at cycle %0d, %s", cycle, fmt(dut_outs()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
